// File: rtl/axis_popcount_pkt.sv
// AXI4-Stream popcount engine: TKEEP-masked beat counts plus MMIO word counts feed a
// saturating running total, and TLAST-delimited packet counts are queued in a result FIFO.
module axis_popcount_pkt #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                      S_AXIS_ACLK,
  input  logic                      S_AXIS_ARESETN,
  input  logic [DATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
  input  logic                      S_AXIS_TLAST,
  input  logic                      S_AXIS_TVALID,
  output logic                      S_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0]     WRITE_DATA,
  input  logic                      WRITE_VALID,
  output logic [COUNT_WIDTH-1:0]    COUNT,
  input  logic                      COUNT_RST,
  output logic                      COUNT_BUSY,
  output logic [COUNT_WIDTH-1:0]    PKT_COUNT_DATA,
  output logic                      PKT_COUNT_VALID,
  input  logic                      PKT_COUNT_POP
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int PC_W   = $clog2(DATA_WIDTH + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);

  function automatic logic [PC_W-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_WIDTH; i++) n = n + PC_W'(v[i]);
    return n;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                     input logic [COUNT_WIDTH-1:0] b);
    logic [COUNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COUNT_WIDTH] ? '1 : s[COUNT_WIDTH-1:0];
  endfunction

  logic [DATA_WIDTH-1:0]  w_keep_mask;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic [AW:0]            w_reserved;
  logic [COUNT_WIDTH-1:0] w_ones_ext;
  logic [COUNT_WIDTH-1:0] w_pkt_sum;

  logic [PC_W-1:0]        r_s1_ones;
  logic [PC_W-1:0]        r_s1_mmio;
  logic                   r_s1_valid;
  logic                   r_s1_last;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] r_pkt_acc;
  logic                   r_pkt_open;

  logic [COUNT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_fill;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it latched.
  always_comb begin
    w_keep_mask = '0;
    for (int i = 0; i < KEEP_W; i++) w_keep_mask[8*i +: 8] = {8{S_AXIS_TKEEP[i]}};
  end

  // A slot is held back for a TLAST already in stage 1, so its push always finds room.
  assign w_reserved    = r_fill + (AW+1)'(r_s1_last);
  assign S_AXIS_TREADY = w_reserved < (AW+1)'(FIFO_DEPTH);
  assign w_accept      = S_AXIS_TVALID & S_AXIS_TREADY;

  assign w_ones_ext = COUNT_WIDTH'(r_s1_ones);
  assign w_pkt_sum  = sat_add(r_pkt_acc, w_ones_ext);
  assign w_push     = r_s1_last & ~COUNT_RST;
  assign w_pop      = PKT_COUNT_POP & PKT_COUNT_VALID;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      r_s1_ones  <= '0;
      r_s1_mmio  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (COUNT_RST) begin
      r_s1_ones  <= '0;
      r_s1_mmio  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_ones  <= w_accept ? popcount(S_AXIS_TDATA & w_keep_mask) : '0;
      r_s1_mmio  <= WRITE_VALID ? popcount(WRITE_DATA) : '0;
      r_s1_valid <= w_accept | WRITE_VALID;
      r_s1_last  <= w_accept & S_AXIS_TLAST;
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      r_count    <= '0;
      r_pkt_acc  <= '0;
      r_pkt_open <= 1'b0;
    end else if (COUNT_RST) begin
      r_count    <= '0;
      r_pkt_acc  <= '0;
      r_pkt_open <= 1'b0;
    end else begin
      r_count   <= sat_add(sat_add(r_count, w_ones_ext), COUNT_WIDTH'(r_s1_mmio));
      r_pkt_acc <= r_s1_last ? '0 : w_pkt_sum;
      if (w_accept) r_pkt_open <= ~S_AXIS_TLAST;
    end
  end

  // NOTE: the result storage has no reset; the read port is forced to zero while empty instead.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (w_push) r_mem[r_wr_ptr] <= w_pkt_sum;
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_fill <= r_fill + (AW+1)'(1);
      else if (w_pop && !w_push) r_fill <= r_fill - (AW+1)'(1);
    end
  end

  assign COUNT           = r_count;
  assign COUNT_BUSY      = r_s1_valid | r_pkt_open;
  assign PKT_COUNT_VALID = (r_fill != '0);
  assign PKT_COUNT_DATA  = PKT_COUNT_VALID ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_axis_popcount_pkt.sv
// Self-checking bench for axis_popcount_pkt: directed vectors, multi-cycle corner
// sequences, and randomized traffic against a packet-level reference model.
module tb_axis_popcount_pkt;

  localparam int DW = 32;
  localparam int FD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DW-1:0] tdata;
  logic [3:0]    tkeep;
  logic          tlast, tvalid, tready;
  logic [DW-1:0] wdata;
  logic          wvalid;
  logic [31:0]   count;
  logic          count_rst, busy;
  logic [31:0]   pkt_data;
  logic          pkt_valid, pkt_pop;

  logic          s_rst_n;
  logic [DW-1:0] s_tdata;
  logic [3:0]    s_tkeep;
  logic          s_tlast, s_tvalid, s_tready;
  logic [6:0]    s_count;
  logic          s_busy;
  logic [6:0]    s_pkt_data;
  logic          s_pkt_valid;

  axis_popcount_pkt #(.DATA_WIDTH(DW), .COUNT_WIDTH(32), .FIFO_DEPTH(FD)) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TDATA(tdata), .S_AXIS_TKEEP(tkeep), .S_AXIS_TLAST(tlast),
    .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready),
    .WRITE_DATA(wdata), .WRITE_VALID(wvalid),
    .COUNT(count), .COUNT_RST(count_rst), .COUNT_BUSY(busy),
    .PKT_COUNT_DATA(pkt_data), .PKT_COUNT_VALID(pkt_valid), .PKT_COUNT_POP(pkt_pop)
  );

  axis_popcount_pkt #(.DATA_WIDTH(DW), .COUNT_WIDTH(7), .FIFO_DEPTH(FD)) dut_sat (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(s_rst_n),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
    .WRITE_DATA('0), .WRITE_VALID(1'b0),
    .COUNT(s_count), .COUNT_RST(1'b0), .COUNT_BUSY(s_busy),
    .PKT_COUNT_DATA(s_pkt_data), .PKT_COUNT_VALID(s_pkt_valid), .PKT_COUNT_POP(1'b0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    tdata = '0; tkeep = '0; tlast = 1'b0; tvalid = 1'b0;
    wdata = '0; wvalid = 1'b0; count_rst = 1'b0; pkt_pop = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
  endtask

  task automatic clear_count();
    idle();
    count_rst = 1'b1;
    tick();
    count_rst = 1'b0;
  endtask

  function automatic int ones_of(input logic [31:0] d, input logic [3:0] k);
    int n;
    n = 0;
    for (int b = 0; b < 4; b++)
      if (k[b]) n += $countones(d[8*b +: 8]);
    return n;
  endfunction

  function automatic longint sat(input longint v, input longint max);
    return (v > max) ? max : v;
  endfunction

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        wv;
    logic [31:0] wd;
    int          exp_count;
    int          exp_pkt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t_cur, t_lag, acc, contrib;
    int     q[$];
    int     pop_pct, o;
    logic   tv, l, wv, pop_now;
    logic [31:0] d, wd;
    logic [3:0]  k;

    vecs[0] = '{32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,         32, 32};
    vecs[1] = '{32'hFFFF_FFFF, 4'h5, 1'b0, 32'h0,         16, 16};
    vecs[2] = '{32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0,          0,  0};
    vecs[3] = '{32'hA5A5_A5A5, 4'h6, 1'b1, 32'hF0,        12,  8};
    vecs[4] = '{32'h8000_0001, 4'h8, 1'b1, 32'hFFFF_FFFF, 33,  1};

    idle();
    s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    rst_n = 1'b0; s_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; s_rst_n = 1'b1;

    check("reset COUNT", count, 0);
    check("reset BUSY", busy, 0);
    check("reset PKT_VALID", pkt_valid, 0);
    check("reset PKT_DATA", pkt_data, 0);
    check("reset TREADY", tready, 1);

    // Single full beat with TLAST; busy must last exactly one cycle.
    beat(32'hFFFF_FFFF, 4'hF, 1'b1);
    tick();
    idle();
    check("first beat BUSY after edge1", busy, 1);
    check("first beat COUNT latency", count, 0);
    tick();
    check("first beat COUNT", count, 32);
    check("first beat PKT_VALID", pkt_valid, 1);
    check("first beat PKT_DATA", pkt_data, 32);
    check("first beat BUSY after edge2", busy, 0);
    pkt_pop = 1'b1;
    tick();
    pkt_pop = 1'b0;
    check("first beat pop empties", pkt_valid, 0);

    // Table of single-beat packets, optionally with a coinciding MMIO write.
    for (int i = 0; i < 5; i++) begin
      clear_count();
      beat(vecs[i].data, vecs[i].keep, 1'b1);
      wvalid = vecs[i].wv;
      wdata  = vecs[i].wd;
      tick();
      idle();
      tick();
      check($sformatf("vec%0d COUNT", i), count, vecs[i].exp_count);
      check($sformatf("vec%0d PKT_VALID", i), pkt_valid, 1);
      check($sformatf("vec%0d PKT_DATA", i), pkt_data, vecs[i].exp_pkt);
      pkt_pop = 1'b1;
      tick();
      pkt_pop = 1'b0;
      check($sformatf("vec%0d popped", i), pkt_valid, 0);
    end

    // Three-beat packet with an MMIO write alongside beat 2.
    clear_count();
    beat(32'h1, 4'hF, 1'b0);
    tick();
    check("3beat BUSY after b1", busy, 1);
    beat(32'h3, 4'hF, 1'b0);
    wvalid = 1'b1; wdata = 32'hF0;
    tick();
    check("3beat BUSY after b2", busy, 1);
    wvalid = 1'b0;
    beat(32'h7, 4'hF, 1'b1);
    tick();
    check("3beat BUSY after last", busy, 1);
    idle();
    tick();
    check("3beat BUSY drops", busy, 0);
    check("3beat COUNT", count, 10);
    check("3beat PKT_DATA", pkt_data, 6);
    pkt_pop = 1'b1;
    tick();
    pkt_pop = 1'b0;

    // Backpressure: five single-beat packets with no pops.
    clear_count();
    for (int i = 1; i <= 4; i++) begin
      beat((32'h1 << i) - 1, 4'hF, 1'b1);
      check($sformatf("bp TREADY before beat%0d", i), tready, 1);
      tick();
    end
    beat(32'h1F, 4'hF, 1'b1);
    check("bp TREADY low after 4", tready, 0);
    tick();
    check("bp TREADY held low", tready, 0);
    tick();
    check("bp TREADY still low", tready, 0);
    pkt_pop = 1'b1;
    check("bp head", pkt_data, 1);
    tick();
    pkt_pop = 1'b0;
    check("bp TREADY after pop", tready, 1);
    tick();
    idle();
    tick();
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("bp pop%0d data", i), pkt_data, i);
      pkt_pop = 1'b1;
      tick();
    end
    pkt_pop = 1'b0;
    check("bp FIFO empty", pkt_valid, 0);
    check("bp COUNT", count, 15);

    // COUNT_RST mid-packet keeps earlier FIFO entries.
    clear_count();
    beat(32'h0F0F, 4'hF, 1'b1);
    tick();
    idle();
    tick();
    beat(32'hFF, 4'hF, 1'b0);
    tick();
    beat(32'h3, 4'hF, 1'b0);
    count_rst = 1'b1;
    tick();
    count_rst = 1'b0;
    beat(32'h1, 4'hF, 1'b1);
    tick();
    idle();
    tick();
    check("crst COUNT", count, 1);
    check("crst BUSY", busy, 0);
    check("crst retained head", pkt_data, 8);
    pkt_pop = 1'b1;
    tick();
    check("crst new packet", pkt_data, 1);
    tick();
    pkt_pop = 1'b0;
    check("crst FIFO empty", pkt_valid, 0);

    // Randomized traffic against the packet-level model.
    clear_count();
    tick();
    t_cur = 0; t_lag = 0; acc = 0;
    for (int c = 0; c < 3000; c++) begin
      check("rand COUNT", count, t_lag);
      pop_pct = ((c / 300) % 2 == 1) ? 70 : 8;
      pop_now = pkt_valid && ($urandom_range(99) < pop_pct);
      if (pop_now) begin
        check("rand pop has model entry", q.size() > 0, 1);
        if (q.size() > 0) check("rand PKT_DATA", pkt_data, q.pop_front());
      end
      pkt_pop = pop_now;
      tv = $urandom_range(99) < 70;
      l  = $urandom_range(99) < 25;
      wv = $urandom_range(99) < 30;
      d  = $urandom() & ($urandom_range(1) ? 32'hFFFF_FFFF : $urandom());
      k  = 4'($urandom());
      wd = $urandom();
      tdata = d; tkeep = k; tlast = l; tvalid = tv; wdata = wd; wvalid = wv;
      t_lag = t_cur;
      contrib = 0;
      if (tv && tready) begin
        o = ones_of(d, k);
        contrib += o;
        acc = sat(acc + o, 64'hFFFF_FFFF);
        if (l) begin
          q.push_back(int'(acc));
          acc = 0;
        end
      end
      if (wv) contrib += $countones(wd);
      t_cur = sat(t_cur + contrib, 64'hFFFF_FFFF);
      tick();
    end
    idle();
    if (acc != 0 || busy) begin
      beat(32'h0, 4'h0, 1'b1);
      while (!tready) begin
        pkt_pop = pkt_valid;
        if (pkt_valid && q.size() > 0) check("rand close PKT_DATA", pkt_data, q.pop_front());
        tick();
      end
      pkt_pop = 1'b0;
      q.push_back(int'(acc));
      acc = 0;
      tick();
      idle();
    end
    tick();
    tick();
    check("rand final COUNT", count, t_cur);
    for (int j = 0; j < FD + 4 && pkt_valid; j++) begin
      check("rand drain has model entry", q.size() > 0, 1);
      if (q.size() > 0) check("rand drain PKT_DATA", pkt_data, q.pop_front());
      pkt_pop = 1'b1;
      tick();
    end
    pkt_pop = 1'b0;
    check("rand drain FIFO empty", pkt_valid, 0);
    check("rand model empty", q.size(), 0);

    // Saturation at COUNT_WIDTH=7, then asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) begin
      s_tdata = 32'hFFFF_FFFF; s_tkeep = 4'hF; s_tlast = (i == 4); s_tvalid = 1'b1;
      tick();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    tick();
    check("sat COUNT", s_count, 127);
    check("sat PKT_VALID", s_pkt_valid, 1);
    check("sat PKT_DATA", s_pkt_data, 127);
    s_tvalid = 1'b1;
    tick();
    tick();
    check("sat BUSY mid-stream", s_busy, 1);
    #2;
    s_rst_n = 1'b0;
    #1;
    check("async COUNT", s_count, 0);
    check("async BUSY", s_busy, 0);
    check("async PKT_VALID", s_pkt_valid, 0);
    check("async PKT_DATA", s_pkt_data, 0);
    check("async TREADY", s_tready, 1);
    s_tvalid = 1'b0;
    @(negedge clk);
    s_rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_popcount_pkt.md
# axis_popcount_pkt

Parametrised AXI4-Stream popcount engine that replaces the fixed 32-bit popcount in the DMA datapath. It adds TKEEP byte masking, a registered count stage, per-packet (TLAST-delimited) counts queued in a result FIFO, and real TREADY backpressure. It sits behind the DMA MM2S stream and the MMIO register block. A running total (COUNT) and per-packet results (PKT_*) are readable by software.

## Interface
Parameters:
- DATA_WIDTH, 32, stream/MMIO data width in bits; a multiple of 8, range 8..512
- COUNT_WIDTH, 32, width of COUNT and packet counts; ≥ clog2(DATA_WIDTH+1)+1
- FIFO_DEPTH, 4, packet-result FIFO entries; a power of 2, ≥ 2

Ports (clock and reset first; one clock; reset is asynchronous and active-low):
- S_AXIS_ACLK  in  1  sole clock, rising edge
- S_AXIS_ARESETN  in  1  asynchronous active-low reset
- S_AXIS_TDATA  in  DATA_WIDTH  stream data
- S_AXIS_TKEEP  in  DATA_WIDTH/8  byte qualifiers; byte i counts only if TKEEP[i]=1
- S_AXIS_TLAST  in  1  last beat of packet
- S_AXIS_TVALID  in  1  beat valid
- S_AXIS_TREADY  out  1  beat accepted when TVALID&TREADY at rising edge
- WRITE_DATA  in  DATA_WIDTH  MMIO word to count (unmasked)
- WRITE_VALID  in  1  single-cycle MMIO strobe
- COUNT  out  COUNT_WIDTH  saturating running total of ones
- COUNT_RST  in  1  synchronous clear
- COUNT_BUSY  out  1  1 while a beat is in the pipe or a packet is open
- PKT_COUNT_DATA  out  COUNT_WIDTH  head-of-FIFO packet count
- PKT_COUNT_VALID  out  1  FIFO not empty
- PKT_COUNT_POP  in  1  dequeue head when PKT_COUNT_VALID=1; ignored when empty

## Operation
- Stage 1 registers the following on every edge:
  - s1_ones = popcount(TDATA & byte-expanded TKEEP), when a beat is accepted; else 0.
  - s1_mmio = popcount(WRITE_DATA), when WRITE_VALID; else 0.
  - s1_valid, which is 1 if either source fired.
  - s1_last = accepted & TLAST.
- Stage 2 (the edge after stage 1):
  - COUNT += s1_ones + s1_mmio, saturating at 2^COUNT_WIDTH−1.
  - pkt_acc += s1_ones, saturating. MMIO never contributes to packet counts.
- On s1_last: push sat(pkt_acc + s1_ones) into the FIFO and clear pkt_acc to 0.
  - A TLAST beat with TKEEP=0 still closes the packet. A zero-count result is pushed.
- A stream beat and an MMIO write in the same cycle are both counted. Neither source has priority.
- S_AXIS_TREADY = (fifo_count + s1_last) < FIFO_DEPTH. It is driven from registers only and never depends on TVALID.
  - This reserves a slot for an in-flight TLAST, so a push never meets a full FIFO.
  - TREADY is low only when the FIFO is full or about to be full. Non-last beats are throttled too.
- FIFO is first-in first-out. Push and pop in the same cycle are allowed; occupancy stays the same.
- COUNT_BUSY = s1_valid | pkt_open. pkt_open is set by an accepted non-last beat and cleared by an accepted last beat.
- COUNT_RST (synchronous, highest priority after reset) clears the following on the same edge:
  - COUNT, pkt_acc, pkt_open and all stage-1 registers.
  - Beats and MMIO writes accepted in the COUNT_RST cycle are discarded. A discarded TLAST pushes nothing.
  - The FIFO contents are preserved.
- Asynchronous reset clears everything, including the FIFO. Deassertion takes effect at the next edge.

## Timing
- Reset values: COUNT=0, COUNT_BUSY=0, PKT_COUNT_VALID=0, PKT_COUNT_DATA=0, S_AXIS_TREADY=1.
- Latency: for a beat or write accepted at edge k, COUNT is updated at edge k+1 and visible during cycle k+1..k+2.
  - A TLAST accepted at edge k makes PKT_COUNT_VALID=1 after edge k+1.
- Throughput: one beat per cycle while TREADY=1.
- Pop at edge k: the next entry, or VALID=0, is presented after edge k.
  - TREADY can rise after edge k, when the pop drops the occupancy below the threshold.
- Reset asserted mid-packet: all outputs return to reset values immediately, without waiting for a clock.

## Test plan
- Reset, then one beat with TDATA=0xFFFFFFFF, TKEEP=0xF, TLAST=1 at edge 1:
  - Required: COUNT=32 after edge 2.
  - Required: PKT_COUNT_VALID=1, PKT_COUNT_DATA=32.
  - Required: COUNT_BUSY=1 for one cycle only.
- Masking: TDATA=0xFFFFFFFF, TKEEP=0x5, TLAST=1.
  - Required: packet count 16, COUNT=16.
  - Then a TKEEP=0x0 TLAST beat is required to push 0.
- Three-beat packet 0x1, 0x3, 0x7 (TLAST on the third), with WRITE_VALID and WRITE_DATA=0xF0 coinciding with beat 2:
  - Required: packet count 6, COUNT=10.
  - Required: COUNT_BUSY high from after edge 1 through the edge after the last beat.
- Backpressure at FIFO_DEPTH=4: stream single-beat packets of 1, 2, 3, 4, 5 ones with no pops.
  - Required: TREADY low once 4 results are reserved; the 5th beat is held.
  - Pop once: required head=1, TREADY high the next cycle, 5th accepted.
  - Subsequent pops are required to return 2, 3, 4, 5 in order.
- COUNT_RST mid-packet: beat 0xFF (not last), then COUNT_RST coinciding with beat 0x3 (not last), then beat 0x1 TLAST.
  - Required: COUNT=1 and packet count 1.
  - Earlier FIFO entries are required to be retained.
- Saturation at COUNT_WIDTH=7, DATA_WIDTH=32: five beats of 0xFFFFFFFF, TLAST on the fifth.
  - Required: COUNT=127, packet count 127.
  - Then assert ARESETN low mid-stream: required all outputs at reset values with no clock edge.
